// File: rtl/button_bank.sv
// button_bank: multi-channel button debouncer with press/release pulses.
//
// Each of NumButtons raw, asynchronous, active-high button inputs has its own
// 2-flop synchronizer, a four-state FSM (idle, press lockout, down, release
// lockout) and a lockout counter. Accepted edges produce single-cycle
// registered pulses; held_o is the debounced level.
//
// Optional feature: define BUTTON_BANK_REPEAT_EN to enable typematic
// auto-repeat. A key held in the down state then re-emits pressed pulses,
// first after RepeatStartCycles and then every RepeatPeriodCycles.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   button_i       raw button levels (asynchronous to clk_i)
//   pressed_o      one-cycle pulse per accepted press (and per repeat)
//   released_o     one-cycle pulse per accepted release
//   held_o         debounced level, high in press lockout and down
//   pressed_any_o  OR of pressed_o, registered in the same cycle as pressed_o
module button_bank #(
  parameter int unsigned NumButtons         = 8,
  parameter int unsigned DelayCycles        = 2000000,
  parameter int unsigned RepeatStartCycles  = 50000000,
  parameter int unsigned RepeatPeriodCycles = 10000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumButtons-1:0] button_i,
  output logic [NumButtons-1:0] pressed_o,
  output logic [NumButtons-1:0] released_o,
  output logic [NumButtons-1:0] held_o,
  output logic                  pressed_any_o
);

  localparam int unsigned MaxAB     = (DelayCycles > RepeatStartCycles) ?
                                      DelayCycles : RepeatStartCycles;
  localparam int unsigned MaxCycles = (MaxAB > RepeatPeriodCycles) ? MaxAB : RepeatPeriodCycles;
  localparam int unsigned CntWidth  = $clog2(MaxCycles) + 1;

  localparam logic [CntWidth-1:0] DelayLast = CntWidth'(DelayCycles - 1);
`ifdef BUTTON_BANK_REPEAT_EN
  localparam logic [CntWidth-1:0] RepStartLast  = CntWidth'(RepeatStartCycles - 1);
  localparam logic [CntWidth-1:0] RepPeriodLast = CntWidth'(RepeatPeriodCycles - 1);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StPressLock,
    StDown,
    StReleaseLock
  } state_e;

  // Next-state press bits, collected for the shared pressed_any register.
  logic [NumButtons-1:0] pressed_d;
  logic                  pressed_any_q;

  for (genvar i = 0; i < NumButtons; i++) begin : g_ch
    logic                sync1_q, sync2_q;
    state_e              state_q, state_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                press_d, release_d, held_d;
    logic                press_q, release_q, held_q;
`ifdef BUTTON_BANK_REPEAT_EN
    // Set after the first repeat so later repeats use the shorter period.
    logic                rep_q, rep_d;
`endif

    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
      rep_d     = rep_q;
`endif
      unique case (state_q)
        StIdle: begin
          if (sync2_q) begin
            state_d = StPressLock;
            count_d = '0;
            press_d = 1'b1;
          end
        end
        StPressLock: begin
          if (count_q == DelayLast) begin
            count_d = '0;
            if (sync2_q) begin
              state_d = StDown;
            end else begin
              // Key already let go: report the release as the lockout ends.
              state_d   = StReleaseLock;
              release_d = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        StDown: begin
          if (!sync2_q) begin
            // Release wins over a repeat falling due in the same cycle.
            state_d   = StReleaseLock;
            count_d   = '0;
            release_d = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
            rep_d     = 1'b0;
`endif
          end else begin
`ifdef BUTTON_BANK_REPEAT_EN
            if ((!rep_q && count_q == RepStartLast) || (rep_q && count_q == RepPeriodLast)) begin
              press_d = 1'b1;
              count_d = '0;
              rep_d   = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
`else
            count_d = '0;
`endif
          end
        end
        StReleaseLock: begin
          if (count_q == DelayLast) begin
            state_d = StIdle;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
      held_d = (state_d == StPressLock) || (state_d == StDown);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        state_q   <= StIdle;
        count_q   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        held_q    <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
        rep_q     <= 1'b0;
`endif
      end else begin
        sync1_q   <= button_i[i];
        sync2_q   <= sync1_q;
        state_q   <= state_d;
        count_q   <= count_d;
        press_q   <= press_d;
        release_q <= release_d;
        held_q    <= held_d;
`ifdef BUTTON_BANK_REPEAT_EN
        rep_q     <= rep_d;
`endif
      end
    end

    assign pressed_d[i]  = press_d;
    assign pressed_o[i]  = press_q;
    assign released_o[i] = release_q;
    assign held_o[i]     = held_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pressed_any_q <= 1'b0;
    end else begin
      pressed_any_q <= |pressed_d;
    end
  end

  assign pressed_any_o = pressed_any_q;

endmodule

// File: tb/tb_button_bank.sv
// Directed testbench for button_bank with DelayCycles=4, RepeatStart=10,
// RepeatPeriod=3. Inputs change on the falling edge; outputs are sampled on
// the falling edge after each rising edge (sample index c follows drive c).
module tb_button_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn;
  logic [7:0] pressed, released, held;
  logic       pressed_any;

  int tests_run;
  int tests_failed;

  button_bank #(
    .NumButtons        (8),
    .DelayCycles       (4),
    .RepeatStartCycles (10),
    .RepeatPeriodCycles(3)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .button_i     (btn),
    .pressed_o    (pressed),
    .released_o   (released),
    .held_o       (held),
    .pressed_any_o(pressed_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic test_reset();
    logic [7:0] exp_p;
    rst_n = 1'b0;
    btn   = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({pressed, released, held, pressed_any} !== 25'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs c=%0d: got p=%h r=%h h=%h any=%b, required all 0",
                 c, pressed, released, held, pressed_any);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp_p = (c == 2) ? 8'hFF : 8'h00;
      tests_run++;
      if (pressed !== exp_p || pressed_any !== (c == 2)) begin
        tests_failed++;
        $display("FAIL reset_first_press c=%0d: got p=%h any=%b, required p=%h any=%b",
                 c, pressed, pressed_any, exp_p, (c == 2));
      end
      if (c == 2) begin
        tests_run++;
        if (held !== 8'hFF) begin
          tests_failed++;
          $display("FAIL reset_held: got %h, required ff", held);
        end
      end
    end
    btn = 8'h00;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int bad;
    btn = 8'h02;
    for (int c = 0; c < 4; c++) @(negedge clk);
    tests_run++;
    if (held !== 8'h02) begin
      tests_failed++;
      $display("FAIL abort_held_before: got %h, required 02", held);
    end
    rst_n = 1'b0;
    btn   = 8'h00;
    #1;
    tests_run++;
    if (held !== 8'h00 || pressed !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_async: got h=%h p=%h, required 00 00", held, pressed);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (released !== 8'h00 || pressed !== 8'h00) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_pulse: got %0d pulse cycles, required 0", bad);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int np, nr, first, held_bad;
    pat = 5'b10101;
    np = 0; nr = 0; first = -1; held_bad = 0;
    for (int c = 0; c < 14; c++) begin
      btn[0] = (c < 5) ? pat[c] : 1'b1;
      @(negedge clk);
      if (pressed[0]) begin
        np++;
        if (first < 0) first = c;
      end
      if (released[0]) nr++;
      if (c >= 2 && held[0] !== 1'b1) held_bad++;
    end
    tests_run++;
    if (np !== 1 || first !== 2) begin
      tests_failed++;
      $display("FAIL bounce_press: got %0d pulses first c=%0d, required 1 at c=2", np, first);
    end
    tests_run++;
    if (nr !== 0) begin
      tests_failed++;
      $display("FAIL bounce_release: got %0d, required 0", nr);
    end
    tests_run++;
    if (held_bad !== 0) begin
      tests_failed++;
      $display("FAIL bounce_held: got %0d low cycles, required 0", held_bad);
    end
    btn = 8'h00;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_short_tap();
    int np, nr, pc, rc, hc, anyc;
    np = 0; nr = 0; pc = -1; rc = -1; hc = 0; anyc = -1;
    for (int c = 0; c < 20; c++) begin
      btn[1] = (c == 0);
      @(negedge clk);
      if (pressed[1]) begin np++; pc = c; end
      if (released[1]) begin nr++; rc = c; end
      if (held[1]) hc++;
      if (pressed_any) anyc = c;
    end
    tests_run++;
    if (np !== 1 || pc !== 2) begin
      tests_failed++;
      $display("FAIL tap_press: got %0d at c=%0d, required 1 at c=2", np, pc);
    end
    tests_run++;
    if (nr !== 1 || rc !== 6) begin
      tests_failed++;
      $display("FAIL tap_release: got %0d at c=%0d, required 1 at c=6", nr, rc);
    end
    tests_run++;
    if (hc !== 4) begin
      tests_failed++;
      $display("FAIL tap_held: got %0d cycles, required 4", hc);
    end
    tests_run++;
    if (anyc !== 2) begin
      tests_failed++;
      $display("FAIL tap_any: got c=%0d, required c=2", anyc);
    end
  endtask

  task automatic test_release_lockout();
    int np, p1, p2, rc;
    np = 0; p1 = -1; p2 = -1; rc = -1;
    for (int c = 0; c < 25; c++) begin
      btn[3] = (c < 10) || (c >= 12);
      @(negedge clk);
      if (pressed[3]) begin
        np++;
        if (p1 < 0) p1 = c;
        else p2 = c;
      end
      if (released[3]) rc = c;
    end
    tests_run++;
    if (rc !== 12) begin
      tests_failed++;
      $display("FAIL lockout_release: got c=%0d, required c=12", rc);
    end
    tests_run++;
    if (np !== 2 || p1 !== 2 || p2 !== 17) begin
      tests_failed++;
      $display("FAIL lockout_repress: got %0d pulses at %0d,%0d, required 2 at 2,17",
               np, p1, p2);
    end
    btn = 8'h00;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_independence();
    btn = 8'h20;
    repeat (10) @(negedge clk);
    btn = 8'h04;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (pressed !== 8'h00 || released !== 8'h00) begin
      tests_failed++;
      $display("FAIL indep_early: got p=%h r=%h, required 00 00", pressed, released);
    end
    @(negedge clk);
    tests_run++;
    if (pressed !== 8'h04 || released !== 8'h20 || pressed_any !== 1'b1) begin
      tests_failed++;
      $display("FAIL indep_pulses: got p=%h r=%h any=%b, required 04 20 1",
               pressed, released, pressed_any);
    end
    tests_run++;
    if (held !== 8'h04) begin
      tests_failed++;
      $display("FAIL indep_held: got %h, required 04", held);
    end
    btn = 8'h00;
    repeat (20) @(negedge clk);
  endtask

  // Held key on channel 6, released so the release lands on a due repeat.
  task automatic test_repeat();
    logic [7:0] exp_p, exp_r;
    logic       rep;
`ifdef BUTTON_BANK_REPEAT_EN
    rep = 1'b1;
`else
    rep = 1'b0;
`endif
    for (int c = 0; c < 40; c++) begin
      btn[6] = (c < 29);
      @(negedge clk);
      exp_p = 8'h00;
      exp_r = 8'h00;
      if (c == 2 || (rep && c >= 16 && c <= 28 && ((c - 16) % 3) == 0)) exp_p = 8'h40;
      if (c == 31) exp_r = 8'h40;
      tests_run++;
      if (pressed !== exp_p || released !== exp_r) begin
        tests_failed++;
        $display("FAIL repeat c=%0d: got p=%h r=%h, required p=%h r=%h",
                 c, pressed, released, exp_p, exp_r);
      end
    end
    btn = 8'h00;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    btn          = 8'h00;
    test_reset();
    test_reset_abort();
    test_bounce();
    test_short_tap();
    test_release_lockout();
    test_independence();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
